// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority encoder with toggle counting.
package enc_pkg;
  localparam int CNT_W_DEF = 16;
  localparam longint unsigned CNT_SAT_DEF = (64'd1 << CNT_W_DEF) - 64'd1;

  // Constant-foldable ceil(log2(v)); v <= 1 yields 0.
  function automatic int enc_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v - 1) >= (1 << i)) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/popcount.sv
// Combinational population count of an N-bit vector; zero latency, no flow control.
module popcount
  import enc_pkg::*;
#(
  parameter int N = 8,
  localparam int PW = enc_clog2(N + 1)
) (
  input  logic [N-1:0]  d,
  output logic [PW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + PW'(d[i]);
    end
  end
endmodule

// File: rtl/priority_encoder_act.sv
// Registered MSB-first priority encoder with saturating input-toggle counter; 1-cycle latency, no backpressure.
// Optional multi_hot flag is built when ENC_ONEHOT_CHECK_EN is defined.
module priority_encoder_act
  import enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = CNT_W_DEF,
  localparam int W    = enc_clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     d,
  input  logic             cnt_clr,
  output logic [W-1:0]     out,
  output logic             any,
  output logic             out_valid,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat
`ifdef ENC_ONEHOT_CHECK_EN
  ,
  output logic             multi_hot
`endif
);
  localparam int PW = enc_clog2(N + 1);
  localparam int SW = CNT_W + 1;
  localparam logic [SW-1:0] SAT_LVL = {1'b0, {CNT_W{1'b1}}};

  logic [N-1:0]  prev_d;
  logic [N-1:0]  diff;
  logic [PW-1:0] toggles;
  logic [W-1:0]  enc;
  logic [SW-1:0] sum;

  assign diff = d ^ prev_d;

  popcount #(.N(N)) u_toggle_pop (
    .d   (diff),
    .cnt (toggles)
  );

  // Ascending scan: the last hit, i.e. the highest set bit, wins.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) enc = W'(i);
    end
  end

  // One extra bit of headroom so overflow is caught before it wraps.
  assign sum = {1'b0, toggle_cnt} + SW'(toggles);

`ifdef ENC_ONEHOT_CHECK_EN
  logic [PW-1:0] ones;

  popcount #(.N(N)) u_ones_pop (
    .d   (d),
    .cnt (ones)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_hot <= 1'b0;
    end else if (in_valid) begin
      multi_hot <= (ones > PW'(1));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      any        <= 1'b0;
      out_valid  <= 1'b0;
      prev_d     <= '0;
      toggle_cnt <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out    <= enc;
        any    <= |d;
        prev_d <= d;
      end
      // A clear discards the toggles of a sample accepted in the same cycle.
      if (cnt_clr) begin
        toggle_cnt <= '0;
        cnt_sat    <= 1'b0;
      end else if (in_valid) begin
        if (sum >= SAT_LVL) begin
          toggle_cnt <= '1;
          cnt_sat    <= 1'b1;
        end else begin
          toggle_cnt <= sum[CNT_W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_act.sv
// Directed bench: an N=4/CNT_W=16 instance and an N=8/CNT_W=4 instance driven in sequence.
module tb_priority_encoder_act;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst4, v4, clr4;
  logic [3:0]  d4;
  logic [1:0]  out4;
  logic        any4, ov4, sat4;
  logic [15:0] cnt4;

  logic        rst8, v8, clr8;
  logic [7:0]  d8;
  logic [2:0]  out8;
  logic        any8, ov8, sat8;
  logic [3:0]  cnt8;
`ifdef ENC_ONEHOT_CHECK_EN
  logic        mh4, mh8;
`endif

  priority_encoder_act #(.N(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .d(d4), .cnt_clr(clr4),
    .out(out4), .any(any4), .out_valid(ov4), .toggle_cnt(cnt4), .cnt_sat(sat4)
`ifdef ENC_ONEHOT_CHECK_EN
    , .multi_hot(mh4)
`endif
  );

  priority_encoder_act #(.N(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .d(d8), .cnt_clr(clr8),
    .out(out8), .any(any8), .out_valid(ov8), .toggle_cnt(cnt8), .cnt_sat(sat8)
`ifdef ENC_ONEHOT_CHECK_EN
    , .multi_hot(mh8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic v, input logic [3:0] d, input logic clr);
    v4 = v; d4 = d; clr4 = clr;
    tick();
  endtask

  task automatic drv8(input logic v, input logic [7:0] d, input logic clr);
    v8 = v; d8 = d; clr8 = clr;
    tick();
  endtask

  task automatic chk4(input string tag, input logic [1:0] o, input logic a, input logic ov,
                      input logic [15:0] c, input logic s);
    chk({tag, ".out"}, 32'(out4), 32'(o));
    chk({tag, ".any"}, 32'(any4), 32'(a));
    chk({tag, ".out_valid"}, 32'(ov4), 32'(ov));
    chk({tag, ".toggle_cnt"}, 32'(cnt4), 32'(c));
    chk({tag, ".cnt_sat"}, 32'(sat4), 32'(s));
  endtask

  task automatic chk8(input string tag, input logic [2:0] o, input logic a, input logic ov,
                      input logic [3:0] c, input logic s);
    chk({tag, ".out"}, 32'(out8), 32'(o));
    chk({tag, ".any"}, 32'(any8), 32'(a));
    chk({tag, ".out_valid"}, 32'(ov8), 32'(ov));
    chk({tag, ".toggle_cnt"}, 32'(cnt8), 32'(c));
    chk({tag, ".cnt_sat"}, 32'(sat8), 32'(s));
  endtask

  initial begin
    rst4 = 1'b1; v4 = 1'b0; clr4 = 1'b0; d4 = 4'h0;
    rst8 = 1'b1; v8 = 1'b0; clr8 = 1'b0; d8 = 8'h00;
    tick();
    tick();
    rst4 = 1'b0;
    rst8 = 1'b0;
    chk4("reset4", 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk8("reset8", 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("reset4.multi_hot", 32'(mh4), 32'd0);
`endif

    // Walking one: toggles 1, 2, 2, 2 accumulate to 1, 3, 5, 7.
    drv4(1'b1, 4'b0001, 1'b0); chk4("walk0", 2'd0, 1'b1, 1'b1, 16'd1, 1'b0);
    drv4(1'b1, 4'b0010, 1'b0); chk4("walk1", 2'd1, 1'b1, 1'b1, 16'd3, 1'b0);
    drv4(1'b1, 4'b0100, 1'b0); chk4("walk2", 2'd2, 1'b1, 1'b1, 16'd5, 1'b0);
    drv4(1'b1, 4'b1000, 1'b0); chk4("walk3", 2'd3, 1'b1, 1'b1, 16'd7, 1'b0);

    // Zero input, then hold with d wiggling while in_valid is low.
    drv4(1'b1, 4'b0000, 1'b0); chk4("zero", 2'd0, 1'b0, 1'b1, 16'd8, 1'b0);
    drv4(1'b0, 4'b1111, 1'b0); chk4("hold0", 2'd0, 1'b0, 1'b0, 16'd8, 1'b0);
    drv4(1'b0, 4'b1010, 1'b0); chk4("hold1", 2'd0, 1'b0, 1'b0, 16'd8, 1'b0);
    drv4(1'b0, 4'b0101, 1'b0); chk4("hold2", 2'd0, 1'b0, 1'b0, 16'd8, 1'b0);
    drv4(1'b0, 4'b1100, 1'b0); chk4("hold3", 2'd0, 1'b0, 1'b0, 16'd8, 1'b0);
    drv4(1'b0, 4'b0110, 1'b0); chk4("hold4", 2'd0, 1'b0, 1'b0, 16'd8, 1'b0);

    // Clear together with a sample: count discarded, prev_d and encode still update.
    drv4(1'b1, 4'b1111, 1'b1); chk4("clr_acc", 2'd3, 1'b1, 1'b1, 16'd0, 1'b0);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("clr_acc.multi_hot", 32'(mh4), 32'd1);
`endif
    drv4(1'b1, 4'b0000, 1'b0); chk4("after_clr", 2'd0, 1'b0, 1'b1, 16'd4, 1'b0);

    // Reset in the same cycle as a sample: nothing survives, no pulse follows.
    rst4 = 1'b1;
    drv4(1'b1, 4'b0101, 1'b0);
    rst4 = 1'b0;
    chk4("rst_mid", 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    drv4(1'b0, 4'b0101, 1'b0); chk4("rst_nopulse", 2'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    drv4(1'b1, 4'b0011, 1'b0); chk4("post_rst", 2'd1, 1'b1, 1'b1, 16'd2, 1'b0);
    drv4(1'b0, 4'b0000, 1'b0);

    // N=8, CNT_W=4: MSB priority and multi-hot flag.
    drv8(1'b1, 8'b0110_0001, 1'b0); chk8("n8_61", 3'd6, 1'b1, 1'b1, 4'd3, 1'b0);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("n8_61.multi_hot", 32'(mh8), 32'd1);
`endif
    drv8(1'b1, 8'b0000_0100, 1'b0); chk8("n8_04", 3'd2, 1'b1, 1'b1, 4'd7, 1'b0);
`ifdef ENC_ONEHOT_CHECK_EN
    chk("n8_04.multi_hot", 32'(mh8), 32'd0);
`endif

    // Saturation: 8, then 16 clamps to 15 and sticks.
    drv8(1'b1, 8'h00, 1'b1); chk8("sat_clr", 3'd0, 1'b0, 1'b1, 4'd0, 1'b0);
    drv8(1'b1, 8'hFF, 1'b0); chk8("sat_a", 3'd7, 1'b1, 1'b1, 4'd8, 1'b0);
    drv8(1'b1, 8'h00, 1'b0); chk8("sat_b", 3'd0, 1'b0, 1'b1, 4'd15, 1'b1);
    drv8(1'b1, 8'hFF, 1'b0); chk8("sat_c", 3'd7, 1'b1, 1'b1, 4'd15, 1'b1);
    drv8(1'b0, 8'h00, 1'b1); chk8("sat_clr2", 3'd7, 1'b1, 1'b0, 4'd0, 1'b0);
    // Landing exactly on all-ones also saturates.
    drv8(1'b1, 8'h00, 1'b0); chk8("exact_a", 3'd0, 1'b0, 1'b1, 4'd8, 1'b0);
    drv8(1'b1, 8'h7F, 1'b0); chk8("exact_b", 3'd6, 1'b1, 1'b1, 4'd15, 1'b1);
    drv8(1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_encoder_act.md
# priority_encoder_act

Parametrised, registered N-to-log2(N) priority encoder with input-activity (toggle) counting for the power-estimation datapath. It replaces the fixed combinational 4-to-2 encoder: any input width, a valid/zero flag, a qualified input strobe, and a saturating count of input bit transitions. It sits between stimulus capture and the activity-accumulation logic.

## Interface
- N, 8: input vector width; N ≥ 2.
- W, $clog2(N): encoded output width; derived, not overridden.
- CNT_W, 16: toggle counter width.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample d this cycle.
- d  in  N  input vector.
- cnt_clr  in  1  clear toggle counter.
- out  out  W  index of highest set bit of last accepted d.
- any  out  1  last accepted d was non-zero.
- out_valid  out  1  out/any updated this cycle (one-cycle pulse).
- toggle_cnt  out  CNT_W  accumulated bit transitions between accepted samples.
- cnt_sat  out  1  toggle_cnt at all-ones (sticky until clear/reset).
- multi_hot  out  1  only with ENC_ONEHOT_CHECK_EN; see Configuration.

## Operation
- Accept: when in_valid=1, d is registered as the new sample; prev_d holds the previous accepted sample.
- Encode: out = highest index i with d[i]=1 (MSB priority; d=0110 → 2). d=0 → out=0, any=0.
- Hold: when in_valid=0, out, any, prev_d and toggle_cnt hold; out_valid=0.
- Toggle count: per accept, toggle_cnt += popcount(d ^ prev_d); prev_d ← d. prev_d resets to 0, so the first sample counts its own set bits.
- Arithmetic: sum computed at CNT_W+1 bits; result ≥ 2^CNT_W−1 → toggle_cnt = all-ones and cnt_sat = 1. No wrap-around.
- cnt_clr: toggle_cnt ← 0, cnt_sat ← 0. Same cycle as in_valid: clear wins, that sample's toggles are discarded; prev_d still updates, out/any/out_valid update normally.
- Reset: out=0, any=0, out_valid=0, toggle_cnt=0, cnt_sat=0, multi_hot=0, prev_d=0. Reset mid-stream discards the in-flight sample; no output pulse follows.

## Timing
- Latency: d sampled on edge k (in_valid=1) → out/any/out_valid valid after edge k, i.e. visible the cycle after in_valid.
- toggle_cnt/cnt_sat reflect sample k after the same edge (1 cycle).
- Back-to-back in_valid every cycle supported; throughput 1 sample/clock.
- No backpressure; no combinational path from inputs to outputs.
- rst has priority over cnt_clr and in_valid.

## Configuration
- ENC_ONEHOT_CHECK_EN defined: multi_hot port exists; registered with out, = 1 when accepted d has more than one bit set (popcount(d) > 1); 0 for zero or one-hot input; holds when in_valid=0; reset 0.
- Not defined: port and its popcount logic absent; all other behaviour identical.

## Structure
- Package enc_pkg: clog2 helper constant function, default CNT_W, toggle-counter saturation constant.
- Sub-module popcount (parameter N, output $clog2(N+1) bits, purely combinational), instantiated for d ^ prev_d and, under ENC_ONEHOT_CHECK_EN, for d.
- Top holds encode loop, sample/prev registers, counter and saturation logic.

## Test plan
- N=4 after reset, in_valid pulses with d = 0001, 0010, 0100, 1000 → out = 0,1,2,3 one cycle later, any=1, toggle_cnt = 1,3,5,7.
- N=4, d=0000 accepted → out=0, any=0, out_valid=1; then in_valid=0 for 5 cycles with d changing → outputs and toggle_cnt hold, out_valid=0.
- N=8, d=0110_0001 → out=6; with ENC_ONEHOT_CHECK_EN multi_hot=1; d=0000_0100 → out=2, multi_hot=0.
- CNT_W=4, N=8, alternate d=FF/00 every cycle → toggle_cnt 8, then 15 with cnt_sat=1, stays 15; cnt_clr → 0, cnt_sat=0.
- cnt_clr and in_valid same cycle (prev_d=0000, d=1111, N=4) → toggle_cnt=0, out=3; next d=0000 → toggle_cnt=4.
- rst asserted in the cycle in_valid=1 → next cycle all outputs 0, out_valid=0; first post-reset sample counted against prev_d=0.
